// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: branch ops, FSM states and the op decoder.
package pc_seq_pkg;

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_B    = 3'd1;
  localparam logic [2:0] OP_CBZ  = 3'd2;
  localparam logic [2:0] OP_CBNZ = 3'd3;
  localparam logic [2:0] OP_BR   = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  typedef struct packed {
    logic legal;
    logic taken;
    logic use_reg;
    logic halt;
  } br_dec_t;

  function automatic br_dec_t br_decode(input logic [2:0] op, input logic zero);
    br_dec_t d;
    d       = '0;
    d.legal = 1'b1;
    case (op)
      OP_SEQ:  d.taken = 1'b0;
      OP_B:    d.taken = 1'b1;
      OP_CBZ:  d.taken = zero;
      OP_CBNZ: d.taken = !zero;
      OP_BR: begin
        d.taken   = 1'b1;
        d.use_reg = 1'b1;
      end
      OP_HALT: d.halt  = 1'b1;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pc_sat_counter.sv
// Saturating event counter used for the retired and taken statistics.
module pc_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: advances the fetch PC, resolves branches, and tracks halt/fault
// and retire/taken statistics.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W       = 64,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                OFFSET_SHIFT = 2,
  parameter int                CNT_W        = 32
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              pc_ready,
  input  logic [2:0]        br_op,
  input  logic [ADDR_W-1:0] br_imm,
  input  logic              br_zero,
  input  logic [ADDR_W-1:0] br_reg,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              redirect,
  output logic              fault,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [ADDR_W-1:0] SEQ_STEP   = ADDR_W'(1) << OFFSET_SHIFT;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = SEQ_STEP - ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic              boot_arm_q, boot_arm_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic              accept, misaligned, ret_inc, tkn_inc;
  logic [ADDR_W-1:0] target;
  br_dec_t           dec;

  assign pc_valid = (state_q == ST_RUN);
  assign accept   = pc_valid && pc_ready;

  always_comb begin
    dec        = br_decode(br_op, br_zero);
    target     = dec.use_reg ? br_reg
                             : pc_q + (dec.taken ? (br_imm << OFFSET_SHIFT) : SEQ_STEP);
    misaligned = |(target & ALIGN_MASK);

    state_d    = state_q;
    boot_arm_d = boot_arm_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    ret_inc    = 1'b0;
    tkn_inc    = 1'b0;
    case (state_q)
      // The release edge only arms BOOT; RUN follows on the next edge.
      ST_BOOT: begin
        if (boot_arm_q) state_d    = ST_RUN;
        else            boot_arm_d = 1'b1;
      end
      ST_RUN: begin
        if (accept) begin
          if (!dec.legal) begin
            state_d = ST_FAULT;
          end else begin
            ret_inc = 1'b1;
            tkn_inc = dec.taken;
            if (dec.halt)        state_d = ST_HALT;
            else if (misaligned) state_d = ST_FAULT;
            else begin
              pc_d       = target;
              redirect_d = dec.taken;
            end
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q    <= ST_BOOT;
      boot_arm_q <= 1'b0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_arm_q <= boot_arm_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  pc_sat_counter #(.CNT_W(CNT_W)) u_retired (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .inc     (ret_inc),
    .cnt     (retired_cnt)
  );

  pc_sat_counter #(.CNT_W(CNT_W)) u_taken (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .inc     (tkn_inc),
    .cnt     (taken_cnt)
  );

  assign pc       = pc_q;
  assign redirect = redirect_q;
  assign fault    = (state_q == ST_FAULT);
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer; narrow counters expose saturation.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int AW = 64;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          Reset_L = 1'b0;
  logic          pc_ready = 1'b0;
  logic [2:0]    br_op = 3'd0;
  logic [AW-1:0] br_imm = '0;
  logic          br_zero = 1'b0;
  logic [AW-1:0] br_reg = '0;
  logic [AW-1:0] pc;
  logic          pc_valid, redirect, fault, halted;
  logic [CW-1:0] retired_cnt, taken_cnt;

  typedef struct {
    string         tag;
    logic [AW-1:0] pc;
    logic          vld, red, flt, hlt;
    logic [CW-1:0] ret, tkn;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int   tests = 0;
  int   failed = 0;

  pc_sequencer #(
    .ADDR_W       (AW),
    .RESET_PC     ('0),
    .OFFSET_SHIFT (2),
    .CNT_W        (CW)
  ) dut (
    .CLK         (CLK),
    .Reset_L     (Reset_L),
    .pc_ready    (pc_ready),
    .br_op       (br_op),
    .br_imm      (br_imm),
    .br_zero     (br_zero),
    .br_reg      (br_reg),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .redirect    (redirect),
    .fault       (fault),
    .halted      (halted),
    .retired_cnt (retired_cnt),
    .taken_cnt   (taken_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic void expect_st(input string tag, input logic [AW-1:0] p,
                                    input logic v, input logic r, input logic f,
                                    input logic h, input int rt, input int tk);
    exp_t e;
    e.tag = tag; e.pc = p; e.vld = v; e.red = r; e.flt = f; e.hlt = h;
    e.ret = CW'(rt); e.tkn = CW'(tk);
    exp_q.push_back(e);
  endfunction

  task automatic step(input string tag, input logic rdy, input logic [2:0] op,
                      input logic [AW-1:0] imm, input logic z, input logic [AW-1:0] rg,
                      input logic [AW-1:0] e_pc, input logic e_vld, input logic e_red,
                      input logic e_flt, input logic e_hlt, input int e_ret, input int e_tkn);
    pc_ready = rdy; br_op = op; br_imm = imm; br_zero = z; br_reg = rg;
    @(posedge CLK);
    expect_st(tag, e_pc, e_vld, e_red, e_flt, e_hlt, e_ret, e_tkn);
    #1;
  endtask

  task automatic do_reset(input string tag);
    Reset_L = 1'b0;
    @(posedge CLK);
    expect_st({tag, "_rst"}, '0, 0, 0, 0, 0, 0, 0);
    #1;
    Reset_L = 1'b1;
    @(posedge CLK);
    expect_st({tag, "_boot"}, '0, 0, 0, 0, 0, 0, 0);
    #1;
    @(posedge CLK);
    expect_st({tag, "_run"}, '0, 1, 0, 0, 0, 0, 0);
    #1;
  endtask

  // Monitor: compares every observed cycle against the next queued expectation.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      tests++;
      if ({pc, pc_valid, redirect, fault, halted, retired_cnt, taken_cnt} !==
          {m.pc, m.vld, m.red, m.flt, m.hlt, m.ret, m.tkn}) begin
        failed++;
        $display("FAIL %s: got pc=%h vld=%b red=%b flt=%b hlt=%b ret=%0d tkn=%0d, want pc=%h vld=%b red=%b flt=%b hlt=%b ret=%0d tkn=%0d",
                 m.tag, pc, pc_valid, redirect, fault, halted, retired_cnt, taken_cnt,
                 m.pc, m.vld, m.red, m.flt, m.hlt, m.ret, m.tkn);
      end
    end
  end

  initial begin
    do_reset("por");

    step("seq0",   1, OP_SEQ,  0, 0, 0, 64'h04, 1, 0, 0, 0, 1, 0);
    step("seq1",   1, OP_SEQ,  0, 0, 0, 64'h08, 1, 0, 0, 0, 2, 0);
    step("seq2",   1, OP_SEQ,  0, 0, 0, 64'h0C, 1, 0, 0, 0, 3, 0);
    step("seq3",   1, OP_SEQ,  0, 0, 0, 64'h10, 1, 0, 0, 0, 4, 0);

    step("cbz_t",  1, OP_CBZ,  64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 64'h08, 1, 1, 0, 0, 5, 1);
    step("seq_a",  1, OP_SEQ,  0, 0, 0, 64'h0C, 1, 0, 0, 0, 6, 1);
    step("seq_b",  1, OP_SEQ,  0, 0, 0, 64'h10, 1, 0, 0, 0, 7, 1);
    step("cbz_nt", 1, OP_CBZ,  64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 64'h14, 1, 0, 0, 0, 8, 1);

    step("b_to20", 1, OP_B,    3, 0, 0, 64'h20, 1, 1, 0, 0, 9, 2);
    for (int i = 0; i < 3; i++)
      step("stall", 0, OP_B,   4, 0, 0, 64'h20, 1, 0, 0, 0, 9, 2);
    step("b_go",   1, OP_B,    4, 0, 0, 64'h30, 1, 1, 0, 0, 10, 3);
    step("stl_red",0, OP_B,    4, 0, 0, 64'h30, 1, 0, 0, 0, 10, 3);

    step("br_mis", 1, OP_BR,   0, 0, 64'h102, 64'h30, 0, 0, 1, 0, 11, 4);
    step("flt_hold",1, OP_SEQ, 0, 0, 0, 64'h30, 0, 0, 1, 0, 11, 4);
    do_reset("flt");

    step("br_top", 1, OP_BR,   0, 0, 64'hFFFF_FFFF_FFFF_FFFC,
                               64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 0, 0, 1, 1);
    step("wrap",   1, OP_SEQ,  0, 0, 0, 64'h0, 1, 0, 0, 0, 2, 1);
    step("halt",   1, OP_HALT, 0, 0, 0, 64'h0, 0, 0, 0, 1, 3, 1);
    step("hlt_hold",1, OP_SEQ, 0, 0, 0, 64'h0, 0, 0, 0, 1, 3, 1);
    do_reset("hlt");

    step("cbnz_t", 1, OP_CBNZ, 2, 0, 0, 64'h08, 1, 1, 0, 0, 1, 1);
    step("cbnz_nt",1, OP_CBNZ, 2, 1, 0, 64'h0C, 1, 0, 0, 0, 2, 1);
    step("illegal",1, 3'd7,    0, 0, 0, 64'h0C, 0, 0, 1, 0, 2, 1);
    do_reset("ill");

    for (int i = 1; i <= 20; i++)
      step("sat", 1, OP_B, 1, 0, 0, AW'(4 * i), 1, 1, 0, 0,
           (i > 15) ? 15 : i, (i > 15) ? 15 : i);
    step("sat_stl",0, OP_B,    1, 0, 0, 64'h50, 1, 0, 0, 0, 15, 15);
    do_reset("stall");

    repeat (2) @(negedge CLK);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 64: PC and target width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter OFFSET_SHIFT, default 2: left shift applied to br_imm before it is added to PC.
REQ-004 SHALL have parameter CNT_W, default 32: width of the statistics counters.
REQ-005 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset_L, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port pc_ready, input, 1 bit: fetch accepts the current PC.
REQ-008 SHALL have port br_op, input, 3 bits: resolved control op of the instruction at PC.
- Encodings: 0 SEQ, 1 B, 2 CBZ, 3 CBNZ, 4 BR, 5 HALT, 6-7 illegal.
REQ-009 SHALL have port br_imm, input, ADDR_W bits: sign-extended branch offset, in instruction units.
REQ-010 SHALL have port br_zero, input, 1 bit: ALU zero flag for CBZ/CBNZ.
REQ-011 SHALL have port br_reg, input, ADDR_W bits: register target for BR.
REQ-012 SHALL have port pc, output, ADDR_W bits: current PC.
REQ-013 SHALL have port pc_valid, output, 1 bit: pc is valid for fetch.
REQ-014 SHALL have port redirect, output, 1 bit: one-cycle pulse, the current PC came from a taken branch.
REQ-015 SHALL have port fault, output, 1 bit: sticky flag for a misaligned target or an illegal op.
REQ-016 SHALL have port halted, output, 1 bit: HALT op accepted.
REQ-017 SHALL have port retired_cnt, output, CNT_W bits: count of accepted instructions.
REQ-018 SHALL have port taken_cnt, output, CNT_W bits: count of taken branches.

Function
REQ-019 SHALL implement the states BOOT, RUN, HALT, FAULT.
- BOOT -> RUN after one cycle.
- RUN -> HALT on an accepted HALT op.
- RUN -> FAULT on an accepted illegal op or a misaligned target.
- HALT and FAULT leave only through reset.
REQ-020 SHALL drive pc_valid high only in RUN.
REQ-021 SHALL define acceptance as pc_valid && pc_ready; br_op, br_imm, br_zero and br_reg are sampled only on acceptance.
REQ-022 SHALL hold pc, the counters and the state unchanged when there is no acceptance (stall); redirect is 0 during a stall.
REQ-023 SHALL determine "taken" on acceptance as follows.
- B: always taken.
- CBZ: taken if br_zero=1.
- CBNZ: taken if br_zero=0.
- BR: always taken.
- SEQ: never taken.
REQ-024 SHALL compute the next PC as follows.
- B, CBZ, CBNZ taken: pc + (br_imm << OFFSET_SHIFT).
- BR taken: br_reg.
- Otherwise: pc + (1 << OFFSET_SHIFT).
- All additions wrap modulo 2^ADDR_W; no overflow flag.
REQ-025 SHALL load the next PC on the rising edge following acceptance (latency 1).
REQ-026 SHALL assert redirect for exactly the cycle after a taken acceptance.
REQ-027 SHALL treat a target with low OFFSET_SHIFT bits nonzero as misaligned: enter FAULT, set fault, hold pc at the faulting instruction, drop pc_valid.
REQ-028 SHALL hold pc on an accepted HALT op; halted rises the next cycle.
REQ-029 SHALL increment retired_cnt on every acceptance, including HALT, and saturate at all-ones.
REQ-030 SHALL increment taken_cnt on every taken acceptance and saturate at all-ones.
REQ-031 SHALL, for an accepted illegal op, leave pc unchanged, enter FAULT and not increment retired_cnt.

Reset
REQ-032 SHALL, when Reset_L=0 at a rising edge, set state=BOOT, pc=RESET_PC, pc_valid=0, redirect=0, fault=0, halted=0, retired_cnt=0, taken_cnt=0.
REQ-033 SHALL give reset priority over any simultaneous acceptance, including a reset asserted mid-stall, in HALT or in FAULT.
REQ-034 SHALL present the first valid PC (RESET_PC) exactly two rising edges after Reset_L returns high: one edge to reach BOOT, one to reach RUN.

Structure
REQ-035 SHALL take the br_op encodings and state encodings from a shared package, pc_seq_pkg, which the decoder also uses.
REQ-036 SHALL instantiate one sub-module, pc_sat_counter (parameterised by CNT_W), once for each of the two counters.
REQ-037 SHALL contain no delay annotations; all timing is cycle-based.

Verification
REQ-038 SHALL cover sequential fetch: reset, pc_ready=1, br_op=SEQ for 4 cycles -> pc sequence 0x0, 0x4, 0x8, 0xC; retired_cnt=4.
REQ-039 SHALL cover CBZ taken and not taken.
- pc=0x10, CBZ, br_imm=-2, br_zero=1 -> pc=0x08, redirect pulse, taken_cnt=1.
- Same with br_zero=0 -> pc=0x14, no redirect.
REQ-040 SHALL cover a stall: pc_ready=0 for 3 cycles with pc=0x20 and br_op=B -> pc stays 0x20, counters unchanged; pc_ready=1 -> branch taken once.
REQ-041 SHALL cover BR fault: BR with br_reg=0x102 -> fault=1, pc stays, pc_valid=0; then Reset_L=0 for 1 cycle -> pc=RESET_PC, fault=0.
REQ-042 SHALL cover wrap and HALT.
- pc=2^64-4, SEQ -> pc=0x0.
- HALT accepted -> halted=1, pc_valid=0, pc frozen.
REQ-043 SHALL cover counter saturation: CNT_W=4, 20 taken B ops -> taken_cnt=15.
